// File: rtl/pcm_pwm_pkg.sv
// pcm_pwm_pkg
// Shared widths and the PCM word layout for the PCM-to-PWM audio output path.
//   PWM_BITS  : width of the PWM carrier counter (256-clock carrier period)
//   CHAN_BITS : width of one channel's duty value
//   PCM_BITS  : width of one stereo PCM word
//   MIDSCALE  : duty that gives a silent DC level (used for the muted underrun)
//   pcm_word_t: stereo word, left duty in [15:8], right duty in [7:0]
package pcm_pwm_pkg;
   localparam int PWM_BITS  = 8;
   localparam int CHAN_BITS = 8;
   localparam int PCM_BITS  = 16;
   localparam logic [CHAN_BITS-1:0] MIDSCALE = 8'd128;

   typedef struct packed {
      logic [CHAN_BITS-1:0] left;
      logic [CHAN_BITS-1:0] right;
   } pcm_word_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo
// Small synchronous FIFO with show-ahead read: rd_data always presents the
// oldest stored word, and rd_en consumes it at the clock edge.
// Ports:
//   clk, srst      : clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data : write strobe and data; ignored while the FIFO is full
//   rd_en          : pop the head word; ignored while the FIFO is empty
//   rd_data        : head word (combinational from the storage array)
//   count          : number of stored words, 0..2^AW
module sample_fifo #(
   parameter int WIDTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             wr_ok;
   logic             rd_ok;

   // Write legality uses the count before any same-cycle pop, so a write
   // into a full FIFO is dropped even when a word leaves on that edge.
   assign wr_ok = wr_en && (count_reg < DEPTH_C);
   assign rd_ok = rd_en && (count_reg != '0);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         // Simultaneous write and read leave the count unchanged.
         case ({wr_ok, rd_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr_reg];
   assign count   = count_reg;
endmodule

// File: rtl/pcm_pwm_out.sv
// pcm_pwm_out
// Buffers 16-bit stereo PCM words and plays them out as two 8-bit unsigned
// PWM streams. One word is popped every SAMPLE_PERIODS carrier periods
// (256 clocks each); left duty comes from pcm[15:8], right from pcm[7:0].
// Ports:
//   clk        : system clock
//   aclr       : synchronous active-high reset (clears FIFO, counters, duty)
//   pcm_rdy    : write strobe, one word accepted per cycle while not full
//   pcm        : stereo PCM word
//   fifo_full  : back-pressure, high when count >= DEPTH-1 (one slot of slack)
//   pwm_l/r    : registered PWM outputs
//   underrun   : one-cycle pulse after a sample tick that found the FIFO empty
//   overflow   : one-cycle pulse after a write that was dropped
// Build option: PCM_PWM_UNDERRUN_MUTE_EN -- when defined, an underrun tick
// loads midscale duty on both channels; otherwise the last sample is held.
module pcm_pwm_out
   import pcm_pwm_pkg::*;
#(
   parameter int FIFO_AW        = 4,
   parameter int SAMPLE_PERIODS = 4
) (
   input  logic                clk,
   input  logic                aclr,
   input  logic                pcm_rdy,
   input  logic [PCM_BITS-1:0] pcm,
   output logic                fifo_full,
   output logic                pwm_l,
   output logic                pwm_r,
   output logic                underrun,
   output logic                overflow
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0] FULL_C  = (FIFO_AW+1)'(DEPTH - 1);
   localparam logic [7:0]       LAST_PERIOD = 8'(SAMPLE_PERIODS - 1);

   logic [FIFO_AW:0]      count;
   logic [PCM_BITS-1:0]   head_bits;
   pcm_word_t             head;
   logic                  tick;
   logic                  has_data;

   logic [PWM_BITS-1:0]   pwm_cnt_reg;
   logic [7:0]            period_cnt_reg;
   logic [CHAN_BITS-1:0]  duty_l_reg;
   logic [CHAN_BITS-1:0]  duty_r_reg;
   logic                  pwm_l_reg;
   logic                  pwm_r_reg;
   logic                  underrun_reg;
   logic                  overflow_reg;

   sample_fifo #(
      .WIDTH (PCM_BITS),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .srst    (aclr),
      .wr_en   (pcm_rdy),
      .wr_data (pcm),
      .rd_en   (tick),
      .rd_data (head_bits),
      .count   (count)
   );

   assign head     = pcm_word_t'(head_bits);
   assign has_data = (count != '0);
   assign tick     = (pwm_cnt_reg == '1) && (period_cnt_reg == LAST_PERIOD);

   always_ff @(posedge clk) begin
      if (aclr) begin
         pwm_cnt_reg    <= '0;
         period_cnt_reg <= '0;
         duty_l_reg     <= '0;
         duty_r_reg     <= '0;
         pwm_l_reg      <= 1'b0;
         pwm_r_reg      <= 1'b0;
         underrun_reg   <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
         if (pwm_cnt_reg == '1) begin
            period_cnt_reg <= (period_cnt_reg == LAST_PERIOD) ? 8'd0
                                                              : period_cnt_reg + 8'd1;
         end

         // Duty loads on the same edge that wraps pwm_cnt to 0, so each new
         // sample starts on a clean carrier period.
         if (tick) begin
            if (has_data) begin
               duty_l_reg <= head.left;
               duty_r_reg <= head.right;
            end else begin
`ifdef PCM_PWM_UNDERRUN_MUTE_EN
               duty_l_reg <= MIDSCALE;
               duty_r_reg <= MIDSCALE;
`else
               duty_l_reg <= duty_l_reg;
               duty_r_reg <= duty_r_reg;
`endif
            end
         end

         underrun_reg <= tick && !has_data;
         overflow_reg <= pcm_rdy && (count == DEPTH_C);

         // Strict less-than gives exactly N high cycles per period for duty N.
         pwm_l_reg <= (pwm_cnt_reg < duty_l_reg);
         pwm_r_reg <= (pwm_cnt_reg < duty_r_reg);
      end
   end

   // Derived from the registered count; the spare slot covers the
   // producer's one-cycle registered reaction to back-pressure.
   assign fifo_full = (count >= FULL_C);
   assign pwm_l     = pwm_l_reg;
   assign pwm_r     = pwm_r_reg;
   assign underrun  = underrun_reg;
   assign overflow  = overflow_reg;
endmodule

// File: doc/pcm_pwm_out.md
# pcm_pwm_out

Downstream consumer of the tone generator's PCM stream. Buffers 16-bit PCM words in a small synchronous FIFO and back-pressures the producer with `fifo_full`. Pops one word per sample period and drives two 8-bit PWM audio outputs: left from `pcm[15:8]`, right from `pcm[7:0]`, both unsigned. Sits between the tone generator and the board's RC-filtered audio pins.

## Interface
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW = 16 words.
- `SAMPLE_PERIODS`, 4: PWM carrier periods (256 clk each) per sample; 50 MHz / 1024 ≈ 48.8 kHz. Legal range 1..255.
- `clk` in 1: single system clock.
- `aclr` in 1: reset, synchronous and active-high (name kept from codebase; NOT asynchronous).
- `pcm_rdy` in 1: write strobe; one word accepted per cycle high.
- `pcm` in 16: `[15:8]` left duty, `[7:0]` right duty.
- `fifo_full` out 1: back-pressure to producer.
- `pwm_l` out 1: left PWM output.
- `pwm_r` out 1: right PWM output.
- `underrun` out 1: one-cycle pulse at a sample tick with FIFO empty.
- `overflow` out 1: one-cycle pulse when a write is dropped.

## Operation
- Reset (aclr=1 at a clk edge): FIFO empty (count=0, pointers 0), `pwm_cnt`=0, `period_cnt`=0, `duty_l`=`duty_r`=0. All outputs 0.
- `fifo_full` = (count >= DEPTH-1). It is derived from the registered count, so it is high with one slot of slack. The slack absorbs the producer's one-cycle registered reaction.
- Write: accepted when `pcm_rdy` && count < DEPTH. Otherwise dropped, and `overflow` pulses the next cycle.
- Full-write legality is judged on pre-read count. A write at count==DEPTH is dropped even if a pop occurs the same cycle.
- `pwm_cnt`: 8-bit free-running counter, wraps 255→0.
- `period_cnt`: increments on each `pwm_cnt` wrap and wraps at SAMPLE_PERIODS-1.
- Sample tick = (`pwm_cnt`==255) && (`period_cnt`==SAMPLE_PERIODS-1).
- On tick with count>0: pop head, load `duty_l`=word[15:8] and `duty_r`=word[7:0].
- On tick with count==0: no pop, `underrun` pulses next cycle, and duty is handled per Configuration.
- Simultaneous write and pop: count unchanged; pointers both advance.
- Output compare: `pwm_l` <= (`pwm_cnt` < `duty_l`), registered; likewise `pwm_r`.
  - duty 0 → constant 0.
  - duty 255 → high 255 of 256 cycles.
  - duty N → exactly N high cycles per carrier period.
- No state machine beyond the counters. The FIFO is the only buffering.

## Timing
- Write at edge N: count, `fifo_full`, and stored data are visible after edge N.
- `fifo_full` rises the cycle after the write that makes count = DEPTH-1.
- First tick after reset release: at the edge ending cycle 256·SAMPLE_PERIODS−1, i.e. cycle 1023 for the default. Counting starts at cycle 0, the first cycle with aclr=0.
- Duty load and `pwm_cnt` wrap to 0 happen on the same edge. The new duty appears on the pwm outputs one cycle later, and every carrier period shows this same one-cycle register lag.
- Pop-to-duty latency: 0 cycles. FIFO read data is read combinationally from the head and registered into duty.
- Reset mid-period: the next edge with aclr=1 zeroes everything. Buffered samples are discarded and the outputs are 0 the following cycle.

## Configuration
- `PCM_PWM_UNDERRUN_MUTE_EN` defined: on an underrun tick, `duty_l`/`duty_r` load midscale 8'd128, giving a silent DC level.
- Not defined: on an underrun tick, duty holds the last sample.
- `underrun` pulses in both builds.

## Structure
- Package `pcm_pwm_pkg`: `PWM_BITS`=8, `CHAN_BITS`=8, `PCM_BITS`=16, `MIDSCALE`=8'd128, and a packed typedef `pcm_word_t` with fields `left` [15:8] and `right` [7:0].
- Sub-module `sample_fifo`, parameterised by width and address width. It provides synchronous write, show-ahead read, and a count output.
- Top level: counters, tick, duty registers, compare, and pulse outputs.

## Test plan
- Reset, then hold `pcm_rdy`=1 with `pcm`=16'h3F7F for 40 cycles, deasserting one cycle after `fifo_full` (mimicking the producer) → count reaches 16, `fifo_full` rises after count 15, no `overflow`.
- Preload one word 16'h807F, run 1100 cycles → tick at cycle 1023, then `pwm_l` high exactly 128 cycles and `pwm_r` high exactly 127 cycles per 256-cycle period.
- Empty FIFO at tick → `underrun` pulses once. With `PCM_PWM_UNDERRUN_MUTE_EN` the duty becomes 128/128; without it the duty holds the previous values.
- Force `pcm_rdy` high for 20 cycles while full → `overflow` pulses on each dropped write. The FIFO contents are the first 16 words in order.
- Write and pop on the same tick cycle with count=5 → count stays 5 and the popped word is the oldest.
- Assert aclr for one cycle mid-period with 8 words buffered → next cycle count=0 and `pwm_l`/`pwm_r`=0. The next tick occurs 1024 cycles after release.
